// File: rtl/capture_sequencer.sv
// Trigger-driven capture controller: circular buffer with pre-trigger history,
// then streams the frame out over a valid/ready port.
module capture_sequencer #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int PRE = 64
) (
    input  logic          Fg_CLK,
    input  logic          RESETn,
    input  logic          Ready,
    input  logic          Enable,
    input  logic [3:0]    Mode,
    input  logic [DW-1:0] Sample,
    input  logic          Arm,
    input  logic          Abort,
    input  logic          ForceTrig,
    input  logic [DW-1:0] TrigLevel,
    input  logic          TrigSlope,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic [DW-1:0] Out_Data,
    output logic          Out_Last,
    output logic          Busy,
    output logic          Done,
    output logic          Err,
    output logic [2:0]    State,
    output logic [AW-1:0] Trig_Addr
);
    // state     | meaning
    // IDLE      | waiting for Arm with Ready high
    // PREFILL   | collecting the first PRE history samples
    // WAIT_TRIG | writing continuously, evaluating the trigger on each Enable
    // POST      | collecting the post-trigger samples
    // READOUT   | streaming DEPTH words starting at the frame start
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFILL   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_READOUT   = 3'd4
    } state_t;

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0]   PRE_M1  = (AW+1)'(PRE - 1);
    localparam logic [AW:0]   POST_M1 = (AW+1)'(DEPTH - PRE - 1);
    localparam logic [AW-1:0] PRE_A   = AW'(PRE);

    state_t        state, state_next;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_cnt, start, trig_start;
    logic [AW:0]   fill, post;
    logic [3:0]    mode_lat;
    logic [DW-1:0] prev;
    logic          force_pend;
    logic          capturing, mode_err, trig_hit, trig_take, write_en, last_xfer;

    assign capturing  = (state == S_PREFILL) || (state == S_WAIT_TRIG) || (state == S_POST);
    assign mode_err   = capturing && (Mode != mode_lat);
    assign trig_hit   = (state == S_WAIT_TRIG) && Enable &&
                        (force_pend ||
                         ( TrigSlope && (prev < TrigLevel) && (Sample >= TrigLevel)) ||
                         (!TrigSlope && (prev > TrigLevel) && (Sample <= TrigLevel)));
    assign trig_take  = trig_hit && !Abort && !mode_err;
    assign write_en   = capturing && Enable && !Abort && !mode_err;
    assign last_xfer  = (state == S_READOUT) && Out_Valid && Out_Ready && Out_Last;
    assign trig_start = wr_ptr - PRE_A;

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (Abort) begin
            state_next = S_IDLE;
        end else if (mode_err) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (Arm && Ready) state_next = S_PREFILL;
                S_PREFILL:   if (Enable && fill == PRE_M1) state_next = S_WAIT_TRIG;
                // with PRE = DEPTH-1 the trigger sample alone completes the frame
                S_WAIT_TRIG: if (trig_hit) state_next = (DEPTH - PRE == 1) ? S_READOUT : S_POST;
                S_POST:      if (Enable && post == POST_M1) state_next = S_READOUT;
                S_READOUT:   if (last_xfer) state_next = S_IDLE;
                default:     state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Busy  = (state != S_IDLE);
        State = state;
    end

    always_ff @(posedge Fg_CLK) begin
        if (write_en) mem[wr_ptr] <= Sample;
    end

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_cnt     <= '0;
            start      <= '0;
            fill       <= '0;
            post       <= '0;
            mode_lat   <= '0;
            prev       <= '0;
            force_pend <= 1'b0;
            Trig_Addr  <= '0;
            Out_Valid  <= 1'b0;
            Out_Data   <= '0;
            Out_Last   <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
        end else begin
            Done <= 1'b0;
            Err  <= mode_err && !Abort;

            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                prev   <= Sample;
            end
            if (state == S_IDLE && state_next == S_PREFILL) begin
                wr_ptr   <= '0;
                fill     <= '0;
                mode_lat <= Mode;
            end
            if (state == S_PREFILL && write_en) fill <= fill + 1'b1;
            if (state == S_POST && write_en)    post <= post + 1'b1;

            if (state_next == S_IDLE || trig_take)  force_pend <= 1'b0;
            else if (capturing && ForceTrig)        force_pend <= 1'b1;

            if (trig_take) begin
                Trig_Addr <= wr_ptr;
                start     <= trig_start;
                post      <= (AW+1)'(1);
            end

            if (state != S_READOUT && state_next == S_READOUT) begin
                rd_ptr    <= (state == S_WAIT_TRIG) ? trig_start : start;
                rd_cnt    <= '0;
                Out_Valid <= 1'b0;
            end

            // output word is registered; it only advances when empty or accepted
            if (state == S_READOUT && !Abort) begin
                if (last_xfer) begin
                    Out_Valid <= 1'b0;
                    Out_Last  <= 1'b0;
                    Done      <= 1'b1;
                end else if (!Out_Valid || Out_Ready) begin
                    Out_Data  <= mem[rd_ptr];
                    Out_Valid <= 1'b1;
                    Out_Last  <= &rd_cnt;
                    rd_ptr    <= rd_ptr + 1'b1;
                    rd_cnt    <= rd_cnt + 1'b1;
                end
            end

            if (Abort) begin
                Out_Valid <= 1'b0;
                Out_Last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: table-driven capture runs with a scoreboard
// queue, plus hand sequences for abort, mode change, gating and reset.
module tb_capture_sequencer;
    localparam int DW = 8, AW = 4, PRE = 4, DEPTH = 16;

    logic          Fg_CLK = 1'b0, RESETn = 1'b0;
    logic          Ready = 1'b0, Enable = 1'b0, Arm = 1'b0, Abort = 1'b0;
    logic          ForceTrig = 1'b0, TrigSlope = 1'b0, Out_Ready = 1'b0;
    logic [3:0]    Mode = 4'd0;
    logic [DW-1:0] Sample = '0, TrigLevel = '0;
    logic          Out_Valid, Out_Last, Busy, Done, Err;
    logic [DW-1:0] Out_Data;
    logic [2:0]    State;
    logic [AW-1:0] Trig_Addr;

    capture_sequencer #(.DW(DW), .AW(AW), .PRE(PRE)) dut (
        .Fg_CLK(Fg_CLK), .RESETn(RESETn), .Ready(Ready), .Enable(Enable),
        .Mode(Mode), .Sample(Sample), .Arm(Arm), .Abort(Abort),
        .ForceTrig(ForceTrig), .TrigLevel(TrigLevel), .TrigSlope(TrigSlope),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
        .Out_Last(Out_Last), .Busy(Busy), .Done(Done), .Err(Err),
        .State(State), .Trig_Addr(Trig_Addr)
    );

    always #5 Fg_CLK = ~Fg_CLK;

    typedef struct {
        string      name;
        int         kind;      // 0 ramp up, 1 ramp down (clamped at 0), 2 constant
        int         start;
        logic       slope;
        logic [7:0] level;
        int         period;
        bit         bp;
        bit         force_t;
        int         exp_taddr;
        int         exp_first;
        int         exp_last;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0, errors = 0;
    int   r = 0;
    byte unsigned exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Fg_CLK);
        #1;
    endtask

    function automatic logic [7:0] gen(input int kind, input int start, input int k);
        if (kind == 0) return 8'(start + k);
        if (kind == 1) return (start - k > 0) ? 8'(start - k) : 8'd0;
        return 8'(start);
    endfunction

    function automatic int model_trig(input vec_t v);
        logic [7:0] a, b;
        for (int k = PRE; k < 200; k++) begin
            a = gen(v.kind, v.start, k - 1);
            b = gen(v.kind, v.start, k);
            if (v.slope ? (a < v.level && b >= v.level) : (a > v.level && b <= v.level))
                return k;
        end
        return 100000;
    endfunction

    task automatic run_vec(input vec_t v);
        int n, trig_k, total, xfers, ro_wait, exp_state, first_w, last_w;
        bit pv, pr, pl, force_issued, fp, done_seen, lat_checked;
        logic [7:0] pd, e;
        exp_q.delete();
        trig_k = v.force_t ? 100000 : model_trig(v);
        total = trig_k + DEPTH - PRE;
        n = 0; xfers = 0; ro_wait = 0; first_w = -1; last_w = -1;
        pv = 0; pr = 0; pl = 0; pd = '0;
        force_issued = 0; done_seen = 0; lat_checked = 0;
        Mode = 4'd1; Ready = 1'b1; TrigLevel = v.level; TrigSlope = v.slope; Out_Ready = 1'b0;
        Arm = 1'b1; Enable = 1'b1; Sample = 8'hEE;   // Enable in the Arm cycle must not be captured
        tick();
        Arm = 1'b0; Enable = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (pv && pr) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    chk({v.name, "_extra_word"}, int'(pd), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk({v.name, "_data"}, int'(pd), int'(e));
                    chk({v.name, "_last_flag"}, int'(pl), int'(exp_q.size() == 0));
                end
                if (xfers == 1) first_w = int'(pd);
                last_w = int'(pd);
                if (pl) begin
                    chk({v.name, "_done"}, int'(Done), 1);
                    chk({v.name, "_end_state"}, int'(State), 0);
                    chk({v.name, "_end_valid"}, int'(Out_Valid), 0);
                    done_seen = 1;
                end
            end else if (pv) begin
                chk({v.name, "_stall_valid"}, int'(Out_Valid), 1);
                chk({v.name, "_stall_data"}, int'(Out_Data), int'(pd));
                chk({v.name, "_stall_last"}, int'(Out_Last), int'(pl));
            end
            if (done_seen) break;
            exp_state = (n < PRE) ? 1 : (n <= trig_k) ? 2 : (n < total) ? 3 : 4;
            chk({v.name, "_state"}, int'(State), exp_state);
            if (exp_state == 4 && !Out_Valid && xfers == 0) ro_wait++;
            if (exp_state == 4 && Out_Valid && !lat_checked) begin
                chk({v.name, "_valid_latency"}, int'(ro_wait <= 2), 1);
                lat_checked = 1;
            end
            pv = Out_Valid; pd = Out_Data; pl = Out_Last;

            fp = force_issued;
            ForceTrig = 1'b0;
            if (v.force_t && !force_issued && State == 3'd2) begin
                ForceTrig = 1'b1;
                force_issued = 1;
            end
            Enable = 1'b0;
            if (n < total && (cyc % v.period) == 0) begin
                if (v.force_t && fp && trig_k == 100000) begin
                    trig_k = n;
                    total = trig_k + DEPTH - PRE;
                end
                Enable = 1'b1;
                Sample = gen(v.kind, v.start, n);
                if (n == trig_k)
                    for (int i = 0; i < DEPTH; i++)
                        exp_q.push_back(gen(v.kind, v.start, trig_k - PRE + i));
                n++;
            end
            Out_Ready = v.bp ? ((cyc % 3) == 0) : 1'b1;
            pr = Out_Ready;
            tick();
        end
        Enable = 1'b0; ForceTrig = 1'b0;
        chk({v.name, "_completed"}, int'(done_seen), 1);
        chk({v.name, "_transfers"}, xfers, DEPTH);
        chk({v.name, "_queue_left"}, exp_q.size(), 0);
        chk({v.name, "_trig_addr"}, int'(Trig_Addr), v.exp_taddr);
        chk({v.name, "_first_word"}, first_w, v.exp_first);
        chk({v.name, "_last_word"}, last_w, v.exp_last);
        tick();
        chk({v.name, "_done_one_cycle"}, int'(Done), 0);
        chk({v.name, "_busy_idle"}, int'(Busy), 0);
    endtask

    task automatic arm_ramp();
        Mode = 4'd1; Ready = 1'b1; TrigLevel = 8'd10; TrigSlope = 1'b1;
        Arm = 1'b1; tick(); Arm = 1'b0;
        r = 0;
    endtask

    task automatic pump_to(input logic [2:0] st, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (State == st) begin
                ok = 1;
                break;
            end
            Enable = 1'b1; Sample = 8'(r); r++;
            tick();
            Enable = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        int cnt;
        bit armed;
        vecs[0] = '{"rise",    0, 0,  1'b1, 8'd10,  1,  0, 0, 10, 6,  21};
        vecs[1] = '{"bkpr",    0, 0,  1'b1, 8'd10,  1,  1, 0, 10, 6,  21};
        vecs[2] = '{"fall",    1, 20, 1'b0, 8'd5,   1,  0, 0, 15, 9,  0};
        vecs[3] = '{"force",   2, 51, 1'b1, 8'hFF,  1,  0, 1, 5,  51, 51};
        vecs[4] = '{"decim",   0, 0,  1'b1, 8'd10,  10, 0, 0, 10, 6,  21};

        RESETn = 1'b0;
        tick(); tick();
        chk("reset_state", int'(State), 0);
        chk("reset_valid", int'(Out_Valid), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_taddr", int'(Trig_Addr), 0);
        RESETn = 1'b1;
        tick();

        Ready = 1'b0; Arm = 1'b1; tick(); Arm = 1'b0;
        chk("arm_not_ready_state", int'(State), 0);
        tick();
        chk("arm_not_ready_busy", int'(Busy), 0);

        for (int t = 0; t < 5; t++) run_vec(vecs[t]);

        // Mode change during POST
        arm_ramp();
        pump_to(3'd3, ok);
        chk("mode_reach_post", int'(ok), 1);
        Mode = 4'd2; Enable = 1'b1; Sample = 8'(r); tick(); Enable = 1'b0;
        chk("mode_err_pulse", int'(Err), 1);
        chk("mode_state", int'(State), 0);
        chk("mode_busy", int'(Busy), 0);
        chk("mode_valid", int'(Out_Valid), 0);
        tick();
        chk("mode_err_single", int'(Err), 0);
        Mode = 4'd1;
        repeat (5) tick();
        chk("mode_no_valid", int'(Out_Valid), 0);

        // Abort in READOUT after 5 words, with a stray Arm in between
        arm_ramp();
        Out_Ready = 1'b1;
        pump_to(3'd4, ok);
        chk("abort_reach_readout", int'(ok), 1);
        cnt = 0; armed = 0;
        for (int i = 0; i < 40 && cnt < 5; i++) begin
            if (Out_Valid) begin
                chk("abort_word", int'(Out_Data), 6 + cnt);
                cnt++;
            end
            Arm = (cnt == 2 && !armed);
            if (Arm) armed = 1;
            tick();
            Arm = 1'b0;
            chk("arm_in_readout_state", int'(State), 4);
        end
        chk("abort_words_seen", cnt, 5);
        Out_Ready = 1'b0; Abort = 1'b1; tick(); Abort = 1'b0;
        chk("abort_valid", int'(Out_Valid), 0);
        chk("abort_last", int'(Out_Last), 0);
        chk("abort_state", int'(State), 0);
        chk("abort_no_done", int'(Done), 0);
        chk("abort_no_err", int'(Err), 0);
        tick();
        chk("abort_no_done_late", int'(Done), 0);

        // Asynchronous reset mid-POST
        arm_ramp();
        pump_to(3'd3, ok);
        chk("rst_reach_post", int'(ok), 1);
        chk("rst_pre_taddr", int'(Trig_Addr), 10);
        RESETn = 1'b0;
        #1;
        chk("rst_state", int'(State), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_taddr", int'(Trig_Addr), 0);
        chk("rst_outs", int'({Out_Valid, Out_Last, Done, Err}), 0);
        chk("rst_data", int'(Out_Data), 0);
        tick();
        RESETn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
